// File: rtl/cpu_prog_driver_if.sv
// Signal bundle between the host/CPU side and cpu_prog_driver.
// master is the host and CPU side; slave is the sequencer itself.
interface cpu_prog_driver_if;
   logic [15:0] load_data;
   logic        load_valid;
   logic        load_ready;
   logic        clear;
   logic        start;
   logic        busy;
   logic [7:0]  cpu_inst;
   logic [7:0]  cpu_opnd;
   logic [7:0]  cpu_data;
   logic [7:0]  res_data;
   logic        res_valid;
   logic        res_ready;

   modport master (
      output load_data, load_valid, clear, start, cpu_data, res_ready,
      input  load_ready, busy, cpu_inst, cpu_opnd, res_data, res_valid
   );

   modport slave (
      input  load_data, load_valid, clear, start, cpu_data, res_ready,
      output load_ready, busy, cpu_inst, cpu_opnd, res_data, res_valid
   );
endinterface

// File: rtl/cpu_prog_driver.sv
// Program sequencer: streams stored 16-bit words onto the CPU pins and
// queues the CPU output byte of every STB/RDS word in a small result FIFO.
module cpu_prog_driver #(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned RES_DEPTH  = 4
) (
   input logic              clk,
   input logic              rst_n,
   cpu_prog_driver_if.slave bus
);
   localparam int unsigned PW = $clog2(PROG_DEPTH);
   localparam int unsigned RW = $clog2(RES_DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e        state_q, state_d;
   logic [15:0]   prog_q [PROG_DEPTH];
   logic [PW:0]   count_q, count_d, pc_q, pc_d;
   logic [7:0]    fifo_q [RES_DEPTH];
   logic [RW-1:0] wptr_q, rptr_q;
   logic [RW:0]   fcount_q;
   logic          tag0_q, tag0_d, tag1_q;
   logic [7:0]    inst_q, inst_d, opnd_q, opnd_d;

   logic [PW-1:0] fetch_idx;
   logic [15:0]   word;
   logic [RW+1:0] pending;
   logic          is_halt, is_cap, stall, issue, load_acc;
   logic          push, pop, busy, load_ready, res_valid;

   // A start in IDLE issues word 0 on the same edge it is sampled.
   assign fetch_idx = (state_q == StIdle) ? '0 : pc_q[PW-1:0];
   assign word      = prog_q[fetch_idx];
   assign is_halt   = (word[15:8] == 8'hFF);
   assign is_cap    = (word[15:12] == 4'h2) || (word[15:12] == 4'h3);
   assign pending   = {1'b0, fcount_q} + {{(RW + 1){1'b0}}, tag0_q}
                    + {{(RW + 1){1'b0}}, tag1_q};
   // Same-cycle pops are not credited, so a full FIFO is never pushed.
   assign stall     = is_cap && (pending >= (RW + 2)'(RES_DEPTH));
   assign push      = tag1_q;
   assign pop       = res_valid && bus.res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start && !bus.clear && (count_q != '0)) state_d = StRun;
         StRun:   if ((pc_q == count_q) || is_halt) state_d = StDrain;
         StDrain: if (!tag0_q) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy       = (state_q != StIdle);
      load_ready = (state_q == StIdle) && (count_q < (PW + 1)'(PROG_DEPTH));
      res_valid  = (fcount_q != '0);
   end

   assign bus.busy       = busy;
   assign bus.load_ready = load_ready;
   assign bus.res_valid  = res_valid;
   assign bus.res_data   = res_valid ? fifo_q[rptr_q] : 8'h00;
   assign bus.cpu_inst   = inst_q;
   assign bus.cpu_opnd   = opnd_q;

   always_comb begin
      count_d  = count_q;
      pc_d     = pc_q;
      inst_d   = 8'h00;
      opnd_d   = 8'h00;
      tag0_d   = 1'b0;
      issue    = 1'b0;
      load_acc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.clear) begin
               count_d = '0;
            end else if (bus.start && (count_q != '0)) begin
               pc_d  = '0;
               issue = !is_halt && !stall;
            end else if (bus.load_valid && load_ready) begin
               load_acc = 1'b1;
               count_d  = count_q + 1'b1;
            end
         end
         StRun:   issue = (pc_q != count_q) && !is_halt && !stall;
         default: ;
      endcase
      if (issue) begin
         inst_d = word[15:8];
         opnd_d = word[7:0];
         tag0_d = is_cap;
         pc_d   = {1'b0, fetch_idx} + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         pc_q     <= '0;
         inst_q   <= 8'h00;
         opnd_q   <= 8'h00;
         tag0_q   <= 1'b0;
         tag1_q   <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         fcount_q <= '0;
      end else begin
         count_q <= count_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         opnd_q  <= opnd_d;
         tag0_q  <= tag0_d;
         tag1_q  <= tag0_q;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop) begin
            fcount_q <= fcount_q + 1'b1;
         end else if (pop && !push) begin
            fcount_q <= fcount_q - 1'b1;
         end
      end
   end

   // Storage arrays need no reset: count and FIFO pointers gate every read.
   always_ff @(posedge clk) begin
      if (load_acc) prog_q[count_q[PW-1:0]] <= bus.load_data;
      if (push)     fifo_q[wptr_q] <= bus.cpu_data;
   end
endmodule

// File: tb/tb_cpu_prog_driver.sv
// Bench for cpu_prog_driver: a small CPU pin model plus an in-order ISA
// reference that predicts the issued word stream and captured results.
module tb_cpu_prog_driver;
   localparam int PD = 16;

   logic clk;
   logic rst_n;
   cpu_prog_driver_if bus ();

   cpu_prog_driver #(.PROG_DEPTH(PD), .RES_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ready_mode = 1;
   int          exp_len;
   logic [15:0] prog [$];
   logic [15:0] exp_iss [$];
   logic [7:0]  exp_res [$];
   logic [15:0] got_iss [$];
   logic [7:0]  got_res [$];
   logic [7:0]  ref_regs [16];
   logic [7:0]  cpu_regs [16];

   // CPU pin model: executes whatever the pins held before each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) cpu_regs[i] <= 8'h00;
         bus.cpu_data <= 8'h00;
      end else begin
         case (bus.cpu_inst[7:4])
            4'h0: cpu_regs[bus.cpu_opnd[7:4]] <= cpu_regs[bus.cpu_opnd[3:0]];
            4'h1: cpu_regs[bus.cpu_inst[3:0]] <= bus.cpu_opnd;
            4'h2: bus.cpu_data <= cpu_regs[bus.cpu_inst[3:0]];
            4'h3: bus.cpu_data <= bus.cpu_opnd ^ cpu_regs[bus.cpu_inst[3:0]];
            default: ;
         endcase
      end
   end

   // Host sink: pick res_ready for the coming edge, then log what it pops.
   always @(negedge clk) begin
      case (ready_mode)
         0:       bus.res_ready = 1'b0;
         1:       bus.res_ready = 1'b1;
         default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.res_valid && bus.res_ready) got_res.push_back(bus.res_data);
      if ({bus.cpu_inst, bus.cpu_opnd} != 16'h0000) got_iss.push_back({bus.cpu_inst, bus.cpu_opnd});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.load_data = 16'h0; bus.load_valid = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
      for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
      prog.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load_word(input logic [15:0] w);
      bus.load_data  = w;
      bus.load_valid = 1'b1;
      if (prog.size() < PD) prog.push_back(w);
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      prog.delete();
   endtask

   // In-order ISA reference; the halt word or the end of the program stops it.
   task automatic build_expect();
      int n_end;
      logic [7:0] op, od;
      exp_iss.delete();
      exp_res.delete();
      n_end = prog.size();
      for (int i = prog.size() - 1; i >= 0; i--) if (prog[i][15:8] == 8'hFF) n_end = i;
      for (int i = 0; i < n_end; i++) begin
         op = prog[i][15:8];
         od = prog[i][7:0];
         exp_iss.push_back(prog[i]);
         case (op[7:4])
            4'h0: ref_regs[od[7:4]] = ref_regs[od[3:0]];
            4'h1: ref_regs[op[3:0]] = od;
            4'h2: exp_res.push_back(ref_regs[op[3:0]]);
            4'h3: exp_res.push_back(od ^ ref_regs[op[3:0]]);
            default: ;
         endcase
      end
      exp_len = (n_end == 0) ? 2 : n_end + 1;
   endtask

   task automatic kick();
      got_iss.delete();
      got_res.delete();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input bit timed);
      int cyc = 0;
      while (bus.busy && cyc < 400) begin
         tick();
         cyc++;
      end
      if (timed) chk({tag, ":busy_len"}, cyc, exp_len);
      else       chk({tag, ":busy_end"}, {31'd0, bus.busy}, 32'd0);
      cyc = 0;
      while (bus.res_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      chk({tag, ":drained"}, {31'd0, bus.res_valid}, 32'd0);
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ":n_iss"}, got_iss.size(), exp_iss.size());
      for (int i = 0; i < got_iss.size() && i < exp_iss.size(); i++)
         chk({tag, ":iss"}, got_iss[i], exp_iss[i]);
      chk({tag, ":n_res"}, got_res.size(), exp_res.size());
      for (int i = 0; i < got_res.size() && i < exp_res.size(); i++)
         chk({tag, ":res"}, got_res[i], exp_res[i]);
   endtask

   task automatic run_prog(input string tag, input bit timed);
      build_expect();
      kick();
      if (timed && exp_iss.size() > 0)
         chk({tag, ":first"}, {bus.cpu_inst, bus.cpu_opnd}, exp_iss[0]);
      wait_idle(tag, timed);
      compare_all(tag);
   endtask

   initial begin
      bus.res_ready = 1'b0;
      do_reset();
      chk("rst_inst", bus.cpu_inst, 8'h00);
      chk("rst_opnd", bus.cpu_opnd, 8'h00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_data", bus.res_data, 8'h00);
      chk("rst_load_ready", bus.load_ready, 1'b1);

      load_word(16'h10A5);
      load_word(16'h0030);
      load_word(16'h2300);
      run_prog("basic", 1'b1);

      do_reset();
      load_word(16'h3000);
      run_prog("rds", 1'b1);

      // Six stores against a 4-entry FIFO with no pops: issue stalls at index 5.
      do_clear();
      load_word(16'h153C);
      for (int i = 0; i < 6; i++) load_word(16'h2500);
      build_expect();
      ready_mode = 0;
      kick();
      repeat (10) tick();
      chk("stall:n_iss", got_iss.size(), 5);
      chk("stall:busy", bus.busy, 1'b1);
      chk("stall:res_valid", bus.res_valid, 1'b1);
      chk("stall:nop", {bus.cpu_inst, bus.cpu_opnd}, 16'h0000);
      ready_mode = 1;
      wait_idle("stall", 1'b0);
      compare_all("stall");

      do_clear();
      load_word(16'h1011);
      load_word(16'hFF00);
      load_word(16'h2000);
      run_prog("halt1", 1'b1);

      do_clear();
      load_word(16'hFF00);
      load_word(16'h2000);
      run_prog("halt0", 1'b1);

      do_clear();
      for (int i = 0; i < 17; i++) load_word(16'h1100 + 16'(i));
      chk("full:load_ready", bus.load_ready, 1'b0);
      run_prog("full", 1'b1);
      do_clear();
      chk("clr:load_ready", bus.load_ready, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("clr:start_ignored", bus.busy, 1'b0);

      for (int r = 0; r < 8; r++) begin
         int n;
         logic [3:0] sel;
         ready_mode = 2;
         if (r % 3 != 2) begin
            do_clear();
            n = $urandom_range(1, PD);
            for (int i = 0; i < n; i++) begin
               sel = 4'($urandom_range(0, 9));
               case (sel)
                  4'd0, 4'd1: load_word({8'h00, 8'($urandom_range(1, 255))});
                  4'd2, 4'd3: load_word({4'h1, 4'($urandom), 8'($urandom)});
                  4'd4, 4'd5, 4'd6: load_word({4'h2, 4'($urandom), 8'($urandom)});
                  4'd7, 4'd8: load_word({4'h3, 4'($urandom), 8'($urandom)});
                  default: load_word(16'hFF00);
               endcase
            end
         end
         run_prog("rand", 1'b0);
      end

      // Reset mid-run with results held in the FIFO.
      ready_mode = 0;
      do_clear();
      load_word(16'h153C);
      load_word(16'h2500);
      load_word(16'h2500);
      for (int i = 0; i < 10; i++) load_word(16'h0011);
      kick();
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("arst:inst", bus.cpu_inst, 8'h00);
      chk("arst:opnd", bus.cpu_opnd, 8'h00);
      chk("arst:busy", bus.busy, 1'b0);
      chk("arst:res_valid", bus.res_valid, 1'b0);
      chk("arst:res_data", bus.res_data, 8'h00);
      chk("arst:load_ready", bus.load_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("arst:start_ignored", bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_prog_driver.md
# cpu_prog_driver

Host-side program sequencer for the 8-bit CPU core. It stores a small program of 16-bit instruction words and streams them one per cycle onto the CPU instruction pins (opcode byte to `ui_in`, operand byte to `uio_in`). It captures the CPU's `uo_out` byte for every store-type instruction (STB, RDS) into a result FIFO that the host drains. It is the initiator for the CPU's pin-level instruction protocol and sits between the test/host logic and the CPU top.

## Interface
- `PROG_DEPTH`, 16: program memory entries (power of two).
- `RES_DEPTH`, 4: result FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load_data`  in  16  program word, `{opcode_byte[15:8], operand_byte[7:0]}`.
- `load_valid`  in  1  host offers `load_data`.
- `load_ready`  out  1  word is accepted on an edge where `load_valid & load_ready`.
- `clear`  in  1  empties program memory (honoured in IDLE only).
- `start`  in  1  begins a run from word 0 (honoured in IDLE with count>0).
- `busy`  out  1  high in RUN and DRAIN.
- `cpu_inst`  out  8  registered; drives CPU `ui_in`.
- `cpu_opnd`  out  8  registered; drives CPU `uio_in`.
- `cpu_data`  in  8  CPU `uo_out`.
- `res_data`  out  8  FIFO head (first-word fall-through).
- `res_valid`  out  1  FIFO non-empty.
- `res_ready`  in  1  host pops the head on an edge where `res_valid & res_ready`.

## Operation
- NOP is `cpu_inst=8'h00, cpu_opnd=8'h00` (MVR R0→R0). It is driven whenever no word is being issued.
- Capture opcodes: `opcode_byte[7:4]` equal to 4'h2 (STB) or 4'h3 (RDS).
- Halt word: `opcode_byte == 8'hFF`. It is never issued and ends the run early.

States:
- IDLE
  - `load_ready = (count < PROG_DEPTH)`. An accepted word is written at index `count`, then `count` increments.
  - `clear` sets `count` to 0. `clear` wins over a simultaneous load.
  - `start` with `count > 0` sets `pc` to 0 and moves to RUN. `start` with `count == 0` is ignored.
  - `start` has priority over load; a simultaneous load is not accepted.
- RUN
  - Each cycle, word[`pc`] is registered onto `cpu_inst`/`cpu_opnd` and `pc` increments, unless the word is stalled.
  - Stall condition: the word is a capture opcode and `fifo_count + inflight ≥ RES_DEPTH`. `inflight` is the number of capture tags in the 2-stage tag pipe. Pops in the same cycle are not credited (conservative).
  - On a stall, NOP is driven and `pc` holds.
  - When `pc == count` or word[`pc`] is a halt word, NOP is driven and the state moves to DRAIN.
- DRAIN
  - NOP is driven until the tag pipe is empty, then the state returns to IDLE.
  - The program is retained, so a new `start` reruns it.
- `load_valid`, `clear` and `start` are ignored while `busy`; `load_ready` is 0.
- Tag pipe: stage0 is set when a capture word is registered onto the pins, stage1 is stage0 delayed one cycle.
  - When stage1 is set, `cpu_data` is pushed into the FIFO on that edge.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - A push is never attempted when full; the stall rule guarantees this.
- FIFO order is strictly issue order.

## Timing
- Reset (async assert) values:
  - `cpu_inst = cpu_opnd = 8'h00`, `busy = 0`, `res_valid = 0`, `res_data = 8'h00`.
  - `load_ready = 1`.
  - `count = 0`, `pc = 0`, FIFO empty, tag pipe clear, state IDLE.
- Reset mid-run aborts immediately. The program and any results are lost.
- Let `start` be sampled at edge E.
  - Word i (no stalls) appears on the pins after edge E+i.
  - The CPU samples word i at edge E+i+1.
  - Its result is pushed at edge E+i+2, and `res_valid` is high after that edge.
- For N words with no stalls or halt:
  - NOP is driven from edge E+N.
  - `busy` rises at E and falls at edge E+N+1, together with the last push.
- Halt at index h behaves as N = h. With h = 0 the run issues nothing and returns to IDLE at E+2.
- Stall cost is one cycle per blocked cycle; non-capture words never stall.

## Test plan
- Load {0x10,0xA5}, {0x00,0x30}, {0x23,0x00}; start at E → pins show 0x10/0xA5, 0x00/0x30, 0x23/0x00 on successive cycles. Exactly one result 0xA5, with `res_valid` after E+4. `busy` falls at E+4.
- Reset, then program {0x30,0x00} (RDS) → single result 0x00.
- LDB R5←0x3C followed by six STB R5 words, `res_ready=0` → exactly 4 results queued and NOPs driven with `pc` held at index 5. Raising `res_ready` delivers six 0x3C results in order, then `busy` falls.
- Program {0x10,0x11}, {0xFF,0x00}, {0x20,0x00} → only the first word is issued, no results, and `busy` falls 2 cycles after the last issue.
- Load 17 words back-to-back → 16 accepted. `load_ready` drops after the 16th; `clear` restores `load_ready=1` with count 0, and `start` is then ignored.
- Assert `rst_n=0` mid-run with 2 results queued → outputs go to reset values immediately. After release, `start` does nothing (count 0).
